rs232_rx_deserializer: RTL and testbench

Receive-side bit engine for the RS-232 interface. It samples the asynchronous `rx` line, recovers start, data, parity and stop bits at mid-bit, and emits one byte per frame with error flags. It sits directly upstream of the receive FIFO: `byte_valid` drives the FIFO push strobe and `data` drives the FIFO input.

---
 rtl/rs232_defs.sv | 36 +++
 rtl/rs232_line_sync.sv | 33 +++
 rtl/rs232_rx_deserializer.sv | 113 +++++++++++
 tb/tb_rs232_rx_deserializer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/rs232_defs.sv
// Shared RS-232 definitions: line-format constants and the exchange-state
// encoding used by both the receive and transmit bit engines.
package rs232_defs;

    localparam int PAR_NONE  = 0;
    localparam int PAR_EVEN  = 1;
    localparam int PAR_ODD   = 2;
    localparam int PAR_MARK  = 3;
    localparam int PAR_SPACE = 4;

    localparam int STOP_1 = 0;
    localparam int STOP_2 = 1;

    localparam int FLOW_NONE   = 0;
    localparam int FLOW_RTSCTS = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } xchg_state_t;

    // Parity bit the line should carry, given the XOR of the data bits.
    function automatic logic parity_expect(input int mode, input logic data_xor);
        case (mode)
            PAR_EVEN: return data_xor;
            PAR_ODD:  return ~data_xor;
            PAR_MARK: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rs232_line_sync.sv
// Two-flop synchronizer for the asynchronous rx pin plus falling-edge detect.
module rs232_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic s1, s2, v1, v2, prev;

    // v1/v2 mark when s1/s2 hold real pin samples rather than reset values, so a
    // line held low through reset is never mistaken for a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            v1   <= 1'b0;
            v2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= rx;
            s2   <= s1;
            v1   <= 1'b1;
            v2   <= v1;
            prev <= s2 & v2;
        end
    end

    assign rx_s = s2;
    assign fall = prev & ~s2;

endmodule

// File: rtl/rs232_rx_deserializer.sv
// RS-232 receive bit engine: mid-bit sampling of start/data/parity/stop,
// one byte_valid pulse per frame with parity and framing flags.
module rs232_rx_deserializer
    import rs232_defs::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 9600,
    parameter int BYTE_LEN  = 8,
    parameter int PARITY    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx,
    input  logic                rx_enable,
    output logic [BYTE_LEN-1:0] data,
    output logic                byte_valid,
    output logic                parity_error,
    output logic                framing_error,
    output logic                busy
);

    localparam logic [31:0] TICKS    = 32'(CLK_FREQ / BAUD_RATE);
    localparam logic [31:0] HALF     = TICKS / 32'd2;
    localparam logic [3:0]  LAST_BIT = 4'(BYTE_LEN - 1);

    logic                rx_s, fall;
    xchg_state_t         state;
    logic [31:0]         cnt;
    logic [3:0]          bit_idx;
    logic [BYTE_LEN-1:0] sr;
    logic                par_err;

    rs232_line_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .rx_s (rx_s),
        .fall (fall)
    );

    // The cycle a bit is sampled is tick 0 of the next interval, so "clearing"
    // the counter loads 1; that keeps the compares at exactly HALF and TICKS.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            sr            <= '0;
            par_err       <= 1'b0;
            data          <= '0;
            byte_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            cnt        <= cnt + 32'd1;
            case (state)
                ST_IDLE: begin
                    if (fall && rx_enable) begin
                        state <= ST_START;
                        cnt   <= 32'd1;
                    end
                end
                ST_START: begin
                    if (cnt == HALF) begin
                        if (rx_s) begin
                            state <= ST_IDLE;
                        end else begin
                            state   <= ST_DATA;
                            cnt     <= 32'd1;
                            bit_idx <= '0;
                            par_err <= 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (cnt == TICKS) begin
                        cnt     <= 32'd1;
                        sr      <= {rx_s, sr[BYTE_LEN-1:1]};
                        bit_idx <= bit_idx + 4'd1;
                        if (bit_idx == LAST_BIT)
                            state <= (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    if (cnt == TICKS) begin
                        cnt     <= 32'd1;
                        par_err <= (rx_s != parity_expect(PARITY, ^sr));
                        state   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // Results are published on the transition into DONE so the
                    // pulse lands at stop sample + 1.
                    if (cnt == TICKS) begin
                        cnt           <= 32'd1;
                        data          <= sr;
                        parity_error  <= par_err;
                        framing_error <= ~rx_s;
                        byte_valid    <= 1'b1;
                        state         <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_START) || (state == ST_DATA) ||
                  (state == ST_PARITY) || (state == ST_STOP);

endmodule

// File: tb/tb_rs232_rx_deserializer.sv
// Randomized bench for rs232_rx_deserializer: drives serial frames and checks
// every byte_valid pulse (cycle, data, flags) against a frame-level model.
module tb_rs232_rx_deserializer;

    localparam int T    = 50000000 / 115200;
    localparam int HALF = T / 2;

    typedef struct {
        int cyc;
        int data;
        bit pe;
        bit fe;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_a = 1'b1, rx_b = 1'b1;
    logic       rx_enable = 1'b1;
    logic [7:0] data_a;
    logic [4:0] data_b;
    logic       bv_a, pe_a, fe_a, busy_a;
    logic       bv_b, pe_b, fe_b, busy_b;

    int  cyc = 0;
    int  n_chk = 0, n_bad = 0;
    ev_t exp_a[$], exp_b[$], obs_a[$], obs_b[$];

    rs232_rx_deserializer #(.CLK_FREQ(50000000), .BAUD_RATE(115200), .BYTE_LEN(8), .PARITY(1)) u_dut_a (
        .clk(clk), .rst(rst), .rx(rx_a), .rx_enable(rx_enable), .data(data_a),
        .byte_valid(bv_a), .parity_error(pe_a), .framing_error(fe_a), .busy(busy_a)
    );

    rs232_rx_deserializer #(.CLK_FREQ(50000000), .BAUD_RATE(115200), .BYTE_LEN(5), .PARITY(0)) u_dut_b (
        .clk(clk), .rst(rst), .rx(rx_b), .rx_enable(rx_enable), .data(data_b),
        .byte_valid(bv_b), .parity_error(pe_b), .framing_error(fe_b), .busy(busy_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ev_t e;
        if (bv_a) begin
            e.cyc = cyc; e.data = int'(data_a); e.pe = pe_a; e.fe = fe_a;
            obs_a.push_back(e);
        end
        if (bv_b) begin
            e.cyc = cyc; e.data = int'(data_b); e.pe = pe_b; e.fe = fe_b;
            obs_b.push_back(e);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic set_rx(input int sel, input logic b);
        if (sel == 0) rx_a = b; else rx_b = b;
    endtask

    task automatic idle(input int sel, input int n);
        set_rx(sel, 1'b1);
        wait_cyc(n);
    endtask

    // Model: a frame sent at cycle n is seen synchronized at t0 = n + 2 and is
    // reported one cycle after the mid-point of its stop bit.
    task automatic send(input int sel, input logic [31:0] d, input bit pflip,
                        input bit stopb, input bit push);
        int  bl  = (sel == 0) ? 8 : 5;
        int  par = (sel == 0) ? 1 : 0;
        ev_t e;
        e.cyc  = cyc + 2 + HALF + (bl + 1 + par) * T + 1;
        e.data = int'(d) & ((1 << bl) - 1);
        e.pe   = (par == 1) && pflip;
        e.fe   = ~stopb;
        if (push) begin
            if (sel == 0) exp_a.push_back(e); else exp_b.push_back(e);
        end
        set_rx(sel, 1'b0);
        wait_cyc(T);
        for (int k = 0; k < bl; k++) begin
            set_rx(sel, d[k]);
            wait_cyc(T);
        end
        if (par == 1) begin
            set_rx(sel, ($countones(d[7:0]) % 2 == 1) ^ pflip);
            wait_cyc(T);
        end
        set_rx(sel, stopb);
        wait_cyc(T);
    endtask

    task automatic drain(input int sel, input string tag);
        ev_t o, e;
        int  no = (sel == 0) ? obs_a.size() : obs_b.size();
        int  ne = (sel == 0) ? exp_a.size() : exp_b.size();
        chk({tag, "_count"}, 64'(no), 64'(ne));
        for (int i = 0; i < ((no < ne) ? no : ne); i++) begin
            if (sel == 0) begin o = obs_a.pop_front(); e = exp_a.pop_front(); end
            else begin o = obs_b.pop_front(); e = exp_b.pop_front(); end
            chk({tag, "_cyc"}, 64'(o.cyc), 64'(e.cyc));
            chk({tag, "_data"}, 64'(o.data), 64'(e.data));
            chk({tag, "_perr"}, 64'(o.pe), 64'(e.pe));
            chk({tag, "_ferr"}, 64'(o.fe), 64'(e.fe));
        end
        if (sel == 0) begin obs_a.delete(); exp_a.delete(); end
        else begin obs_b.delete(); exp_b.delete(); end
    endtask

    initial begin
        int n;
        wait_cyc(3);
        chk("rst_data", 64'(data_a), 0);
        chk("rst_valid", 64'(bv_a), 0);
        chk("rst_perr", 64'(pe_a), 0);
        chk("rst_ferr", 64'(fe_a), 0);
        chk("rst_busy", 64'(busy_a), 0);
        rst = 1'b0;
        wait_cyc(5);

        send(0, 32'hA5, 0, 1, 1); idle(0, T);
        drain(0, "nominal");
        send(0, 32'hA5, 1, 1, 1); idle(0, T);
        drain(0, "parity");
        send(0, $urandom_range(0, 255), 1'($urandom), 1'($urandom), 1); idle(0, T);
        drain(0, "random");

        // Framing error on an all-zero frame, then the line stays low (break).
        send(0, 32'h00, 0, 0, 1);
        set_rx(0, 1'b0); wait_cyc(20 * T);
        idle(0, T);
        drain(0, "break");
        send(0, 32'h3C, 0, 1, 1); idle(0, T);
        drain(0, "after_break");

        n = cyc;
        set_rx(0, 1'b0); wait_cyc(100); set_rx(0, 1'b1);
        chk("glitch_busy_start", 64'(busy_a), 1);
        wait_cyc(n + 2 + HALF - cyc);
        chk("glitch_busy_sample", 64'(busy_a), 1);
        wait_cyc(1);
        chk("glitch_busy_drop", 64'(busy_a), 0);
        idle(0, T);
        drain(0, "glitch");

        set_rx(0, 1'b0); rst = 1'b1; wait_cyc(3); rst = 1'b0;
        wait_cyc(HALF + 50);
        chk("rstlow_busy", 64'(busy_a), 0);
        idle(0, 20);
        drain(0, "rst_low");

        fork
            send(0, 32'h5A, 0, 1, 0);
            begin
                wait_cyc(4 * T + 200);
                rst = 1'b1;
                wait_cyc(1);
                chk("midrst_out", 64'({data_a, bv_a, pe_a, fe_a, busy_a}), 0);
                wait_cyc(7 * T);
            end
        join
        rst = 1'b0;
        idle(0, T);
        send(0, 32'h5A, 0, 1, 1); idle(0, T);
        drain(0, "after_rst");

        rx_enable = 1'b0;
        send(0, $urandom_range(0, 255), 0, 1, 0);
        idle(0, T / 2);
        rx_enable = 1'b1;
        drain(0, "en_off");
        fork
            send(0, $urandom_range(0, 255), 1'($urandom), 1, 1);
            begin wait_cyc(3 * T); rx_enable = 1'b0; end
        join
        idle(0, T);
        rx_enable = 1'b1;
        drain(0, "en_drop");

        fork
            begin send(0, 32'h00, 0, 1, 1); send(0, 32'hFF, 0, 1, 1); idle(0, T); end
            begin send(1, 32'h15, 0, 1, 1); send(1, $urandom_range(0, 31), 0, 1, 1); idle(1, T); end
        join
        drain(0, "gap8");
        drain(1, "gap5");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
